// File: rtl/spi_read.sv
// SPI mode-0 read master: clocks one Width-bit word in from an ADC, MSB first,
// with cs/dclk derived from clk_i through a programmable phase divider.
module spi_read #(
  parameter int Width    = 16,
  parameter int DivWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                strr_i,
  input  logic [DivWidth-1:0] kmax_i,
  input  logic                miso_i,
  output logic [Width-1:0]    data_o,
  output logic                cs_o,
  output logic                dclk_o,
  output logic                busy_o,
  output logic                eor_o
);

  localparam int CntWidth = $clog2(Width + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(Width);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_r;
  logic [DivWidth-1:0] div_r;
  logic [DivWidth-1:0] kmax_r;
  logic [CntWidth-1:0] cnt_r;
  logic [Width-1:0]    shift_r;
  logic                tick_s;

  // Phase tick: last clk cycle of the current dclk phase.
  assign tick_s = (div_r == kmax_r);

  // Frame sequencer; every output is set on the edge that enters the state it belongs to.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
      div_r   <= {DivWidth{1'b0}};
      kmax_r  <= {DivWidth{1'b0}};
      cnt_r   <= {CntWidth{1'b0}};
      shift_r <= {Width{1'b0}};
      data_o  <= {Width{1'b0}};
      cs_o    <= 1'b1;
      dclk_o  <= 1'b0;
      busy_o  <= 1'b0;
      eor_o   <= 1'b0;
    end else begin
      eor_o <= 1'b0;
      case (state_r)
        IDLE: begin
          div_r  <= {DivWidth{1'b0}};
          dclk_o <= 1'b0;
          if (strr_i) begin
            state_r <= START;
            kmax_r  <= kmax_i;
            cnt_r   <= {CntWidth{1'b0}};
            cs_o    <= 1'b0;
            busy_o  <= 1'b1;
          end else begin
            cs_o   <= 1'b1;
            busy_o <= 1'b0;
          end
        end
        START, LOW: begin
          if (tick_s) begin
            // Rising dclk edge: this is where miso is sampled.
            state_r <= HIGH;
            div_r   <= {DivWidth{1'b0}};
            dclk_o  <= 1'b1;
            shift_r <= {shift_r[Width-2:0], miso_i};
            cnt_r   <= cnt_r + CntWidth'(1);
          end else begin
            div_r <= div_r + DivWidth'(1);
          end
        end
        HIGH: begin
          if (tick_s) begin
            div_r  <= {DivWidth{1'b0}};
            dclk_o <= 1'b0;
            if (cnt_r == CntLast) begin
              state_r <= DONE;
              cs_o    <= 1'b1;
              data_o  <= shift_r;
              eor_o   <= 1'b1;
            end else begin
              state_r <= LOW;
            end
          end else begin
            div_r <= div_r + DivWidth'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          cnt_r   <= {CntWidth{1'b0}};
          div_r   <= {DivWidth{1'b0}};
          busy_o  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CntWidth{1'b0}};
          div_r   <= {DivWidth{1'b0}};
          cs_o    <= 1'b1;
          dclk_o  <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_read.sv
// Randomized self-checking bench for spi_read: an ADC model feeds miso, and the
// expected cycle-by-cycle waveform is computed from the frame timing formulas.
module tb_spi_read;

  localparam int W = 16;

  logic          clk_i;
  logic          rst_i;
  logic          strr_i;
  logic [7:0]    kmax_i;
  logic          miso_i;
  logic [W-1:0]  data_o;
  logic          cs_o;
  logic          dclk_o;
  logic          busy_o;
  logic          eor_o;

  int            n_cmp;
  int            n_err;
  logic [W-1:0]  adc_word;
  int            adc_idx;
  logic [W-1:0]  exp_data;

  spi_read #(.Width(W), .DivWidth(8)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .strr_i (strr_i),
    .kmax_i (kmax_i),
    .miso_i (miso_i),
    .data_o (data_o),
    .cs_o   (cs_o),
    .dclk_o (dclk_o),
    .busy_o (busy_o),
    .eor_o  (eor_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ADC model: presents MSB while cs is high, moves to the next bit on each dclk fall.
  always @(posedge cs_o or negedge dclk_o) begin
    if (cs_o) adc_idx = W - 1;
    else if (adc_idx > 0) adc_idx = adc_idx - 1;
  end
  assign miso_i = adc_word[adc_idx];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_cs"},   32'(cs_o),   32'd1);
    check_eq({tag, "_dclk"}, 32'(dclk_o), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
    check_eq({tag, "_eor"},  32'(eor_o),  32'd0);
    check_eq({tag, "_data"}, 32'(data_o), 32'(exp_data));
  endtask

  // Called at a negedge with the DUT idle; strr is sampled on the next posedge (cycle 0).
  task automatic run_frame(input logic [W-1:0] word, input int km, input bit hold, input int poke);
    int k;
    int last;
    bit cs_e, dclk_e, busy_e, eor_e;
    k    = km + 1;
    last = 2 * W * k;
    adc_word = word;
    kmax_i   = 8'(km);
    strr_i   = 1'b1;
    for (int c = 1; c <= last + 2; c++) begin
      @(negedge clk_i);
      if (c == 1 && !hold) strr_i = 1'b0;
      if (poke > 0 && c == poke) begin
        strr_i = 1'b1;
        kmax_i = 8'd7;
      end
      if (poke > 0 && c == poke + 1) strr_i = 1'b0;
      cs_e   = !(c <= last);
      dclk_e = (c <= last) && (((c - 1) / k) % 2 == 1);
      busy_e = (c <= last + 1);
      eor_e  = (c == last + 1);
      if (c == last + 1) exp_data = word;
      check_eq("cs",   32'(cs_o),   32'(cs_e));
      check_eq("dclk", 32'(dclk_o), 32'(dclk_e));
      check_eq("busy", 32'(busy_o), 32'(busy_e));
      check_eq("eor",  32'(eor_o),  32'(eor_e));
      check_eq("data", 32'(data_o), 32'(exp_data));
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    exp_data = '0;
    adc_word = '0;
    rst_i    = 1'b0;
    strr_i   = 1'b0;
    kmax_i   = 8'd0;
    repeat (3) @(negedge clk_i);
    check_idle("reset");
    rst_i = 1'b1;
    @(negedge clk_i);
    check_idle("post_reset");

    // basic read, fastest divider, back-to-back, busy-ignore with kmax change
    run_frame(16'hA5C3, 3, 1'b0, 0);
    run_frame(16'h8001, 0, 1'b0, 0);
    run_frame(16'h1234, 3, 1'b1, 0);
    run_frame(16'hFEDC, 3, 1'b0, 0);
    run_frame(16'h3C96, 3, 1'b0, 20);
    repeat (4) begin
      @(negedge clk_i);
      check_idle("no_restart");
    end

    // reset in the middle of a frame
    kmax_i   = 8'd3;
    adc_word = 16'hBEEF;
    strr_i   = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk_i);
      if (c == 1) strr_i = 1'b0;
    end
    check_eq("pre_rst_cs", 32'(cs_o), 32'd0);
    rst_i = 1'b0;
    exp_data = '0;
    #1;
    check_idle("async_rst");
    repeat (3) begin
      @(negedge clk_i);
      check_idle("in_rst");
    end
    rst_i = 1'b1;
    run_frame(16'h00FF, 3, 1'b0, 0);

    // stuck-at patterns
    run_frame(16'hFFFF, 1, 1'b0, 0);
    run_frame(16'h0000, 2, 1'b0, 0);

    // randomized frames with random divider and random back-to-back chaining
    for (int i = 0; i < 12; i++) begin
      run_frame(16'($urandom), int'($urandom_range(0, 5)), (i != 11) && ($urandom_range(0, 1) == 1), 0);
    end
    repeat (3) begin
      @(negedge clk_i);
      check_idle("final_idle");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
